sync_parallel_counter: RTL and testbench



---
 rtl/sync_parallel_counter.sv | 90 +++++++++
 tb/tb_sync_parallel_counter.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/sync_parallel_counter.sv
// sync_parallel_counter: generic up/down counter with parallel load and a
// synchronous reset to a parameterised initial value.
// Latency: one cycle; a request sampled at a rising edge is visible on value
// right after that edge. There is no handshake; every edge applies the request.
//
// Parameters:
//   size        counter width in bits (>= 1)
//   init_value  value forced by reset; truncated to size bits
//
// Ports:
//   clock       system clock, all updates on the rising edge
//   reset       synchronous, active-high; forces value to init_value
//   load        parallel load strobe (beats inc/dec)
//   load_value  value written when load=1
//   inc_enable  increment request
//   dec_enable  decrement request
//   value       current count, straight from the state register
//
// Optional build macro SYNC_PARALLEL_COUNTER_SATURATE_EN: when defined, the
// count clamps at 2^size-1 on increment and at 0 on decrement instead of
// wrapping. Load and reset are unaffected.

module sync_parallel_counter #(
  parameter int size       = 8,
  parameter int init_value = 0
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            load,
  input  logic [size-1:0] load_value,
  input  logic            inc_enable,
  input  logic            dec_enable,
  output logic [size-1:0] value
);

  // Oversized init values are cut down to the counter width.
  localparam logic [size-1:0] init_trunc = size'(init_value);
  localparam logic [size-1:0] one        = size'(1);
  localparam logic [size-1:0] max_count  = '1;

  logic [size-1:0] count_q;
  logic [size-1:0] count_d;
  logic            do_inc;
  logic            do_dec;

  // Simultaneous inc and dec cancel out, so only one-sided requests count.
  assign do_inc = inc_enable & ~dec_enable;
  assign do_dec = dec_enable & ~inc_enable;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_value;
    end else if (do_inc) begin
`ifdef SYNC_PARALLEL_COUNTER_SATURATE_EN
      if (count_q != max_count) begin
        count_d = count_q + one;
      end
`else
      count_d = count_q + one;
`endif
    end else if (do_dec) begin
`ifdef SYNC_PARALLEL_COUNTER_SATURATE_EN
      if (count_q != '0) begin
        count_d = count_q - one;
      end
`else
      count_d = count_q - one;
`endif
    end
  end

  // Reset sits in the clocked block so it outranks load/inc/dec at the edge.
  always_ff @(posedge clock) begin
    if (reset) begin
      count_q <= init_trunc;
    end else begin
      count_q <= count_d;
    end
  end

  assign value = count_q;

`ifndef SYNC_PARALLEL_COUNTER_SATURATE_EN
  // In the wrapping build max_count is only a named bound, not used in logic.
  logic unused_max;
  assign unused_max = &max_count;
`endif

endmodule

// File: tb/tb_sync_parallel_counter.sv
// Testbench for sync_parallel_counter (size=3, init_value=2).
// Directed vectors push their hand-computed expected value into a queue as
// they are driven; a monitor pops and compares 4 time units after each edge.

module tb_sync_parallel_counter;

`ifdef SYNC_PARALLEL_COUNTER_SATURATE_EN
  localparam bit sat = 1'b1;
`else
  localparam bit sat = 1'b0;
`endif

  logic       clock;
  logic       reset;
  logic       load;
  logic [2:0] load_value;
  logic       inc_enable;
  logic       dec_enable;
  logic [2:0] value;

  logic [2:0] exp_q[$];
  string      name_q[$];
  int         checks = 0;
  int         passed = 0;
  int         model;

  sync_parallel_counter #(.size(3), .init_value(2)) dut (
    .clock      (clock),
    .reset      (reset),
    .load       (load),
    .load_value (load_value),
    .inc_enable (inc_enable),
    .dec_enable (dec_enable),
    .value      (value)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Inputs change on the falling edge; the expected result of the following
  // rising edge is queued at the same moment.
  task automatic drive(input logic r, input logic l, input logic [2:0] lv,
                       input logic i, input logic d, input logic [2:0] exp,
                       input string nm);
    @(negedge clock);
    reset      = r;
    load       = l;
    load_value = lv;
    inc_enable = i;
    dec_enable = d;
    exp_q.push_back(exp);
    name_q.push_back(nm);
  endtask

  // Monitor: the counter presents a result after every edge that consumed
  // a queued request.
  always @(posedge clock) begin
    #4;
    if (exp_q.size() != 0) begin
      logic [2:0] e;
      string      n;
      e = exp_q.pop_front();
      n = name_q.pop_front();
      checks++;
      if (value === e) begin
        passed++;
      end else begin
        $display("FAIL %s: value=%0d expected=%0d", n, value, e);
      end
    end
  end

  initial begin
    reset      = 1'b0;
    load       = 1'b0;
    load_value = 3'd0;
    inc_enable = 1'b0;
    dec_enable = 1'b0;

    // Reset beats load and inc.
    drive(1, 1, 3'd5, 1, 0, 3'd2, "reset_dominates");
    // Load beats inc.
    drive(0, 1, 3'd6, 1, 0, 3'd6, "load_dominates_inc");
    // Increment across the top.
    drive(0, 0, 3'd0, 1, 0, 3'd7,             "inc_6_to_7");
    drive(0, 0, 3'd0, 1, 0, sat ? 3'd7 : 3'd0, "inc_wrap_top");
    drive(0, 0, 3'd0, 1, 0, sat ? 3'd7 : 3'd1, "inc_after_top");
    // Restart from 1 and decrement across the bottom.
    drive(0, 1, 3'd1, 0, 0, 3'd1,             "load_1");
    drive(0, 0, 3'd0, 0, 1, 3'd0,             "dec_1_to_0");
    drive(0, 0, 3'd0, 0, 1, sat ? 3'd0 : 3'd7, "dec_wrap_bottom");
    drive(0, 0, 3'd0, 0, 1, sat ? 3'd0 : 3'd6, "dec_after_bottom");
    // Simultaneous inc and dec, then idle.
    drive(0, 1, 3'd4, 0, 1, 3'd4, "load_dominates_dec");
    drive(0, 0, 3'd0, 1, 1, 3'd4, "inc_dec_cancel_a");
    drive(0, 0, 3'd0, 1, 1, 3'd4, "inc_dec_cancel_b");
    drive(0, 0, 3'd0, 0, 0, 3'd4, "idle_hold");
    // Load of max and zero are accepted in both builds.
    drive(0, 1, 3'd7, 0, 0, 3'd7, "load_max");
    drive(0, 1, 3'd0, 1, 0, 3'd0, "load_zero_over_inc");
    // Reset in the middle of counting.
    drive(0, 0, 3'd0, 1, 0, 3'd1, "inc_0_to_1");
    drive(1, 0, 3'd0, 1, 0, 3'd2, "reset_mid_inc");
    drive(1, 1, 3'd7, 0, 1, 3'd2, "reset_over_load_dec");

    // Pseudo-random phase against an arithmetic reference model.
    model = 2;
    for (int k = 0; k < 300; k++) begin
      logic       r, l, i, d;
      logic [2:0] lv;
      r  = ($urandom_range(0, 19) == 0);
      l  = ($urandom_range(0, 5) == 0);
      lv = 3'($urandom_range(0, 7));
      i  = 1'($urandom_range(0, 1));
      d  = 1'($urandom_range(0, 1));
      if (r)              model = 2;
      else if (l)         model = int'(lv);
      else if (i && !d)   model = sat ? ((model == 7) ? 7 : model + 1) : (model + 1) % 8;
      else if (d && !i)   model = sat ? ((model == 0) ? 0 : model - 1) : (model + 7) % 8;
      drive(r, l, lv, i, d, 3'(model), "random");
    end

    @(negedge clock);
    reset      = 1'b0;
    load       = 1'b0;
    inc_enable = 1'b0;
    dec_enable = 1'b0;
    for (int k = 0; k < 20 && exp_q.size() != 0; k++) @(posedge clock);
    #6;
    if (exp_q.size() != 0) begin
      checks++;
      $display("FAIL drain: pending=%0d expected=0", exp_q.size());
    end
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
